// File: rtl/mm_pkg.sv
// Shared types for the 2x2 matrix-multiply sequencer: element/result widths,
// sequencer state encoding, matrix containers and the per-job operand mux.
package mm_pkg;

   localparam int unsigned ELEM_W = 8;
   localparam int unsigned RES_W  = 18;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_e;

   // m[row][col], row-major
   typedef logic [1:0][1:0][ELEM_W-1:0] mat2x2_t;
   typedef logic [1:0][1:0][RES_W-1:0]  res2x2_t;

   typedef struct packed {
      logic [ELEM_W-1:0] row0;
      logic [ELEM_W-1:0] row1;
      logic [ELEM_W-1:0] col0;
      logic [ELEM_W-1:0] col1;
   } ops_t;

   // Job idx computes C[idx[1]][idx[0]]: row idx[1] of A against column idx[0] of B
   function automatic ops_t sel_ops(input mat2x2_t a, input mat2x2_t b,
                                    input logic [IDX_W-1:0] idx);
      ops_t o;
      o.row0 = a[idx[1]][0];
      o.row1 = a[idx[1]][1];
      o.col0 = b[0][idx[0]];
      o.col1 = b[1][idx[0]];
      return o;
   endfunction

endpackage

// File: rtl/mm2x2_seq.sv
// Sequencer computing C = A x B for 2x2 matrices by issuing four dot-product
// jobs to the ALU over a start/complete handshake and collecting the results.
module mm2x2_seq
   import mm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ELEM_W-1:0] a00,
   input  logic [ELEM_W-1:0] a01,
   input  logic [ELEM_W-1:0] a10,
   input  logic [ELEM_W-1:0] a11,
   input  logic [ELEM_W-1:0] b00,
   input  logic [ELEM_W-1:0] b01,
   input  logic [ELEM_W-1:0] b10,
   input  logic [ELEM_W-1:0] b11,
   output logic              ready,
   output logic              done,
   output logic              error,
   output logic [RES_W-1:0]  c00,
   output logic [RES_W-1:0]  c01,
   output logic [RES_W-1:0]  c10,
   output logic [RES_W-1:0]  c11,
   output logic              alu_start,
   output logic [ELEM_W-1:0] alu_row0,
   output logic [ELEM_W-1:0] alu_row1,
   output logic [ELEM_W-1:0] alu_col0,
   output logic [ELEM_W-1:0] alu_col1,
   input  logic [RES_W-1:0]  alu_out,
   input  logic              alu_complete
);

   state_e              state_q, state_d;
   mat2x2_t             a_q, a_d, b_q, b_d;
   res2x2_t             c_q, c_d;
   ops_t                ops_q, ops_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                start_q, start_d;

   mat2x2_t             a_in, b_in;

   assign a_in = {a11, a10, a01, a00};
   assign b_in = {b11, b10, b01, b00};

   // Next-state and registered-output logic; outputs are computed for the state being entered
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      ops_d   = ops_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      error_d = error_q;
      done_d  = 1'b0;
      start_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               a_d     = a_in;
               b_d     = b_in;
               c_d     = '0;
               error_d = 1'b0;
               idx_d   = '0;
               ops_d   = sel_ops(a_in, b_in, IDX_W'(0));
               start_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A completion in the timeout cycle still counts
            if (alu_complete) begin
               c_d[idx_q[1]][idx_q[0]] = alu_out;
               if (idx_q == IDX_W'(3)) begin
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  ops_d   = sel_ops(a_q, b_q, idx_q + IDX_W'(1));
                  start_d = 1'b1;
                  state_d = ISSUE;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         ops_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         ops_q   <= ops_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         error_q <= error_d;
         start_q <= start_d;
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign error     = error_q;
   assign alu_start = start_q;
   assign alu_row0  = ops_q.row0;
   assign alu_row1  = ops_q.row1;
   assign alu_col0  = ops_q.col0;
   assign alu_col1  = ops_q.col1;
   assign c00       = c_q[0][0];
   assign c01       = c_q[0][1];
   assign c10       = c_q[1][0];
   assign c11       = c_q[1][1];

endmodule

// File: tb/tb_mm2x2_seq.sv
// Bench for mm2x2_seq: behavioural ALU responder with programmable latency,
// reference matrix product and operand order, directed and random runs.
module tb_mm2x2_seq;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic [7:0]  a00 = '0, a01 = '0, a10 = '0, a11 = '0;
   logic [7:0]  b00 = '0, b01 = '0, b10 = '0, b11 = '0;
   logic        ready, done, error, alu_start;
   logic [17:0] c00, c01, c10, c11;
   logic [7:0]  alu_row0, alu_row1, alu_col0, alu_col1;
   logic [17:0] alu_out = '0;
   logic        alu_complete = 1'b0;

   mm2x2_seq #(.TIMEOUT(TO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a00(a00), .a01(a01), .a10(a10), .a11(a11),
      .b00(b00), .b01(b01), .b10(b10), .b11(b11),
      .ready(ready), .done(done), .error(error),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .alu_start(alu_start),
      .alu_row0(alu_row0), .alu_row1(alu_row1),
      .alu_col0(alu_col0), .alu_col1(alu_col1),
      .alu_out(alu_out), .alu_complete(alu_complete)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          resp_k = 3;
   bit          resp_en = 1'b1;
   bit          resp_spur = 1'b0;
   int          starts = 0;
   logic [31:0] ops_log[$];
   logic [17:0] resp_val;
   int          ma[2][2];
   int          mb[2][2];

   // ALU responder: completes resp_k cycles after the start cycle, optionally
   // with a bogus strobe inside the start cycle itself
   always begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
         starts++;
         ops_log.push_back({alu_row0, alu_row1, alu_col0, alu_col1});
         resp_val = 18'(int'(alu_row0) * int'(alu_col0) + int'(alu_row1) * int'(alu_col1));
         if (resp_spur) begin
            alu_complete = 1'b1;
            alu_out      = 18'h3ABCD;
         end
         if (resp_en) begin
            for (int k = 0; k < resp_k; k++) begin
               @(posedge clk);
               #1 alu_complete = 1'b0;
            end
            alu_out      = resp_val;
            alu_complete = 1'b1;
            @(posedge clk);
            #1 alu_complete = 1'b0;
         end else begin
            @(posedge clk);
            #1 alu_complete = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_c(input int i, input int j);
      return 32'(ma[i][0] * mb[0][j] + ma[i][1] * mb[1][j]);
   endfunction

   function automatic logic [31:0] exp_ops(input int idx);
      int i = idx / 2;
      int j = idx % 2;
      return {8'(ma[i][0]), 8'(ma[i][1]), 8'(mb[0][j]), 8'(mb[1][j])};
   endfunction

   task automatic set_inputs();
      a00 = 8'(ma[0][0]); a01 = 8'(ma[0][1]); a10 = 8'(ma[1][0]); a11 = 8'(ma[1][1]);
      b00 = 8'(mb[0][0]); b01 = 8'(mb[0][1]); b10 = 8'(mb[1][0]); b11 = 8'(mb[1][1]);
   endtask

   task automatic set_mats(input int x0, input int x1, input int x2, input int x3,
                           input int y0, input int y1, input int y2, input int y3);
      ma[0][0] = x0; ma[0][1] = x1; ma[1][0] = x2; ma[1][1] = x3;
      mb[0][0] = y0; mb[0][1] = y1; mb[1][0] = y2; mb[1][1] = y3;
   endtask

   task automatic check_c(input string tag);
      check({tag, ".c00"}, 32'(c00), exp_c(0, 0));
      check({tag, ".c01"}, 32'(c01), exp_c(0, 1));
      check({tag, ".c10"}, 32'(c10), exp_c(1, 0));
      check({tag, ".c11"}, 32'(c11), exp_c(1, 1));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ready"}, 32'(ready), 32'd1);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".error"}, 32'(error), 32'd0);
      check({tag, ".start"}, 32'(alu_start), 32'd0);
      check({tag, ".ops"}, {alu_row0, alu_row1, alu_col0, alu_col1}, 32'd0);
      check({tag, ".c"}, 32'(c00 | c01 | c10 | c11), 32'd0);
   endtask

   // One full multiply; entered just after a posedge with the DUT idle
   task automatic run_mult(input string tag, input int k, input bit spur, input bit hold);
      int cyc;
      resp_k = k; resp_spur = spur; resp_en = 1'b1;
      starts = 0;
      ops_log.delete();
      set_inputs();
      req = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) req = 1'b0;
      cyc = 1;
      check({tag, ".start1"}, 32'(alu_start), 32'd1);
      check({tag, ".busy"}, 32'(ready), 32'd0);
      check({tag, ".errclr"}, 32'(error), 32'd0);
      while (done !== 1'b1 && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, ".latency"}, 32'(cyc), 32'(4 * (k + 1) + 1));
      check({tag, ".starts"}, 32'(starts), 32'd4);
      check({tag, ".error"}, 32'(error), 32'd0);
      check_c(tag);
      check({tag, ".nops"}, 32'(ops_log.size()), 32'd4);
      for (int n = 0; n < 4 && n < ops_log.size(); n++)
         check($sformatf("%s.ops%0d", tag, n), ops_log[n], exp_ops(n));
      @(posedge clk);
      #1;
      check({tag, ".donepulse"}, 32'(done), 32'd0);
      check({tag, ".ready"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int cyc;
      bit saw_done;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: basic product
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      run_mult("t1", 3, 1'b0, 1'b0);

      // 2: full-scale operands, no truncation
      set_mats(255, 255, 255, 255, 255, 255, 255, 255);
      run_mult("t2", 2, 1'b0, 1'b0);
      check("t2.max", 32'(c11), 32'h1FC02);

      // 3: identity times B, operand order checked inside run_mult
      set_mats(1, 0, 0, 1, 'h10, 'h20, 'h30, 'h40);
      run_mult("t3", 1, 1'b0, 1'b0);

      // 4: responder silent -> timeout
      resp_en = 1'b0; resp_spur = 1'b0; starts = 0;
      set_mats(9, 9, 9, 9, 9, 9, 9, 9);
      set_inputs();
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      cyc = 1;
      saw_done = 1'b0;
      while (error !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("t4.tocycle", 32'(cyc), 32'(TO + 2));
      check("t4.error", 32'(error), 32'd1);
      check("t4.ready", 32'(ready), 32'd1);
      check("t4.nodone", 32'(saw_done), 32'd0);
      check("t4.starts", 32'(starts), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("t4.sticky", 32'(error), 32'd1);
      set_mats(2, 3, 4, 5, 6, 7, 8, 9);
      run_mult("t4b", 2, 1'b0, 1'b0);

      // 5: reset during job 2 wait, late completion must be ignored
      resp_k = 3; resp_en = 1'b1; resp_spur = 1'b0; starts = 0;
      set_mats(11, 12, 13, 14, 15, 16, 17, 18);
      set_inputs();
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      cyc = 0;
      while (starts < 3 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("t5.reach", 32'(starts), 32'd3);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_zero("t5.rst");
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_zero("t5.late");
      check("t5.nostart", 32'(starts), 32'd3);
      run_mult("t5b", 3, 1'b0, 1'b0);

      // 6: req held high, spurious strobe in every ISSUE cycle
      set_mats(7, 1, 2, 9, 3, 4, 5, 6);
      run_mult("t6a", 2, 1'b1, 1'b1);
      set_mats(200, 100, 50, 25, 1, 2, 3, 4);
      run_mult("t6b", 2, 1'b1, 1'b1);
      req = 1'b0;
      @(posedge clk);
      #1;

      // Random operands and ALU latency
      for (int r = 0; r < 8; r++) begin
         set_mats($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255),
                  $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
         run_mult($sformatf("rnd%0d", r), $urandom_range(6, 1), 1'($urandom_range(1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
